riscv_sim_monitor: RTL and testbench

Parametrised end-of-simulation monitor for multi-core vector simulators.
- Watches the per-core CSR status words and per-core retire strobes, and counts cycles and retired instructions for each core.
- Combines per-core outcomes into one pass/fail/timeout verdict, then drains for a fixed number of cycles before requesting finish.
- Sits in the simulator top between the core array and the host-side $finish/stat-print logic. It replaces that logic's inline status-change, timeout and stats handling, which was hard-wired to a single core.

---
 rtl/riscv_sim_monitor_pkg.sv | 21 ++
 rtl/riscv_sim_core_tracker.sv | 42 ++++
 rtl/riscv_sim_monitor.sv | 152 +++++++++++++++
 tb/tb_riscv_sim_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sim_monitor_pkg.sv
// Shared verdict codes, FSM states and status constants for the simulation monitor.
// Replaces the former riscvvec-SimMonitorDefs.v define header.
package riscv_sim_monitor_pkg;

    typedef enum logic [1:0] {
        VERDICT_NONE    = 2'd0,
        VERDICT_PASS    = 2'd1,
        VERDICT_FAIL    = 2'd2,
        VERDICT_TIMEOUT = 2'd3
    } verdict_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned STATUS_RUNNING = 0;
    localparam int unsigned STATUS_PASS    = 1;

endpackage

// File: rtl/riscv_sim_core_tracker.sv
// Per-core tracker: sticky done bit, first non-zero status latch and a
// saturating retired-instruction counter.
module riscv_sim_core_tracker
    import riscv_sim_monitor_pkg::*;
#(
    parameter int STATUS_W = 32,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                stats_en,
    input  logic [STATUS_W-1:0] status,
    input  logic                inst_retire,
    output logic                core_done,
    output logic [STATUS_W-1:0] eff_status,
    output logic [CNT_W-1:0]    num_inst
);

    logic [STATUS_W-1:0] latched_status;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_done      <= 1'b0;
            latched_status <= '0;
            num_inst       <= '0;
        end else if (run) begin
            if (!core_done && status != STATUS_W'(STATUS_RUNNING)) begin
                core_done      <= 1'b1;
                latched_status <= status;
            end
            // core_done is the pre-edge value, so the reporting cycle's retire still counts
            if (stats_en && inst_retire && !core_done && num_inst != '1) begin
                num_inst <= num_inst + 1'b1;
            end
        end
    end

    // The verdict logic sees this cycle's status until the latch takes over.
    assign eff_status = core_done ? latched_status : status;

endmodule

// File: rtl/riscv_sim_monitor.sv
// End-of-simulation monitor: combines per-core outcomes into one verdict,
// counts cycles, then drains before requesting finish.
module riscv_sim_monitor
    import riscv_sim_monitor_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int STATUS_W     = 32,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2,
    localparam int SEL_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CNT_W-1:0]              max_cycles,
    input  logic                          stats_en,
    input  logic [NUM_CORES*STATUS_W-1:0] status,
    input  logic [NUM_CORES-1:0]          inst_retire,
    input  logic [SEL_W-1:0]              stat_sel,
    output logic [1:0]                    verdict,
    output logic [SEL_W-1:0]              fail_core,
    output logic [STATUS_W-1:0]           fail_status,
    output logic [NUM_CORES-1:0]          core_done,
    output logic [CNT_W-1:0]              num_cycles,
    output logic [CNT_W-1:0]              stat_num_inst,
    output logic                          finish_req,
    output logic                          done
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e                              state_q, state_d;
    verdict_e                            verdict_q, verdict_d;
    logic [SEL_W-1:0]                    fail_core_d;
    logic [STATUS_W-1:0]                 fail_status_d;
    logic [DW-1:0]                       drain_q, drain_d;
    logic                                finish_d;
    logic                                run;
    logic [NUM_CORES-1:0][STATUS_W-1:0]  eff_status;
    logic [NUM_CORES-1:0][CNT_W-1:0]     inst_cnt;
    logic                                fail_hit, all_pass, timeout_hit;
    logic [SEL_W-1:0]                    fail_idx;
    logic [STATUS_W-1:0]                 fail_val;

    assign run = (state_q == ST_RUN);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        riscv_sim_core_tracker #(
            .STATUS_W (STATUS_W),
            .CNT_W    (CNT_W)
        ) u_trk (
            .clk         (clk),
            .reset_n     (reset_n),
            .run         (run),
            .stats_en    (stats_en),
            .status      (status[g*STATUS_W +: STATUS_W]),
            .inst_retire (inst_retire[g]),
            .core_done   (core_done[g]),
            .eff_status  (eff_status[g]),
            .num_inst    (inst_cnt[g])
        );
    end

    // Descending scan so the lowest failing index wins.
    always_comb begin
        fail_hit = 1'b0;
        fail_idx = '0;
        fail_val = '0;
        all_pass = 1'b1;
        for (int unsigned i = NUM_CORES; i > 0; i--) begin
            if (eff_status[i-1] > STATUS_W'(STATUS_PASS)) begin
                fail_hit = 1'b1;
                fail_idx = SEL_W'(i - 1);
                fail_val = eff_status[i-1];
            end
            if (eff_status[i-1] != STATUS_W'(STATUS_PASS)) begin
                all_pass = 1'b0;
            end
        end
        timeout_hit = (max_cycles != '0) && (num_cycles >= max_cycles);
    end

    always_comb begin
        stat_num_inst = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (stat_sel == SEL_W'(i)) begin
                stat_num_inst = inst_cnt[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        verdict_d     = verdict_q;
        fail_core_d   = fail_core;
        fail_status_d = fail_status;
        drain_d       = drain_q;
        finish_d      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fail_hit) begin
                    verdict_d     = VERDICT_FAIL;
                    fail_core_d   = fail_idx;
                    fail_status_d = fail_val;
                end else if (all_pass) begin
                    verdict_d = VERDICT_PASS;
                end else if (timeout_hit) begin
                    verdict_d = VERDICT_TIMEOUT;
                end
                if (fail_hit || all_pass || timeout_hit) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d  = ST_DONE;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            verdict_q   <= VERDICT_NONE;
            fail_core   <= '0;
            fail_status <= '0;
            drain_q     <= '0;
            finish_req  <= 1'b0;
            num_cycles  <= '0;
        end else begin
            state_q     <= state_d;
            verdict_q   <= verdict_d;
            fail_core   <= fail_core_d;
            fail_status <= fail_status_d;
            drain_q     <= drain_d;
            finish_req  <= finish_d;
            if (run && stats_en && num_cycles != '1) begin
                num_cycles <= num_cycles + 1'b1;
            end
        end
    end

    assign verdict = verdict_q;
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// Directed self-checking bench for riscv_sim_monitor.
module tb_riscv_sim_monitor;

    localparam int NC = 4;
    localparam int SW = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [CW-1:0]     max_cycles;
    logic              stats_en;
    logic [NC*SW-1:0]  status;
    logic [NC-1:0]     inst_retire;
    logic [1:0]        stat_sel;
    logic [1:0]        verdict;
    logic [1:0]        fail_core;
    logic [SW-1:0]     fail_status;
    logic [NC-1:0]     core_done;
    logic [CW-1:0]     num_cycles;
    logic [CW-1:0]     stat_num_inst;
    logic              finish_req;
    logic              done;

    logic [3:0]        s_max_cycles;
    logic [23:0]       s_status;
    logic [2:0]        s_retire;
    logic [1:0]        s_sel;
    logic [1:0]        s_verdict;
    logic [1:0]        s_fail_core;
    logic [7:0]        s_fail_status;
    logic [2:0]        s_core_done;
    logic [3:0]        s_num_cycles;
    logic [3:0]        s_num_inst;
    logic              s_finish_req;
    logic              s_done;

    int errors = 0;
    int checks = 0;

    riscv_sim_monitor #(
        .NUM_CORES    (NC),
        .STATUS_W     (SW),
        .CNT_W        (CW),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .max_cycles    (max_cycles),
        .stats_en      (stats_en),
        .status        (status),
        .inst_retire   (inst_retire),
        .stat_sel      (stat_sel),
        .verdict       (verdict),
        .fail_core     (fail_core),
        .fail_status   (fail_status),
        .core_done     (core_done),
        .num_cycles    (num_cycles),
        .stat_num_inst (stat_num_inst),
        .finish_req    (finish_req),
        .done          (done)
    );

    riscv_sim_monitor #(
        .NUM_CORES    (3),
        .STATUS_W     (8),
        .CNT_W        (4),
        .DRAIN_CYCLES (2)
    ) dut_sat (
        .clk           (clk),
        .reset_n       (reset_n),
        .max_cycles    (s_max_cycles),
        .stats_en      (stats_en),
        .status        (s_status),
        .inst_retire   (s_retire),
        .stat_sel      (s_sel),
        .verdict       (s_verdict),
        .fail_core     (s_fail_core),
        .fail_status   (s_fail_status),
        .core_done     (s_core_done),
        .num_cycles    (s_num_cycles),
        .stat_num_inst (s_num_inst),
        .finish_req    (s_finish_req),
        .done          (s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        stats_en     = 1'b0;
        max_cycles   = '0;
        status       = '0;
        inst_retire  = '0;
        stat_sel     = '0;
        s_max_cycles = '0;
        s_status     = '0;
        s_retire     = '0;
        s_sel        = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        stats_en    = 1'b1;
        status      = '1;
        inst_retire = '1;
        max_cycles  = 32'd1;
        tick();
        checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL reset_verdict: got %0d expected 0", verdict); end
        checks++; if (core_done !== 4'h0) begin errors++; $display("FAIL reset_core_done: got %h expected 0", core_done); end
        checks++; if (num_cycles !== 32'd0) begin errors++; $display("FAIL reset_num_cycles: got %0d expected 0", num_cycles); end
        checks++; if (finish_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_finish_done: got %b%b expected 00", finish_req, done); end
        checks++; if (stat_num_inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %0d expected 0", stat_num_inst); end
    endtask

    task automatic test_all_pass();
        do_reset();
        stats_en   = 1'b1;
        max_cycles = 32'd1000;
        for (int c = 0; c <= 43; c++) begin
            for (int i = 0; i < NC; i++) begin
                inst_retire[i]     = (c >= 1 && c <= 10 * (i + 1));
                status[i*SW +: SW] = (c >= 10 * (i + 1)) ? 32'd1 : 32'd0;
            end
            tick();
            if (c == 39) begin
                checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL pass_early_verdict: got %0d expected 0", verdict); end
            end
            if (c == 40) begin
                checks++; if (verdict !== 2'd1) begin errors++; $display("FAIL pass_verdict: got %0d expected 1", verdict); end
                checks++; if (core_done !== 4'hF) begin errors++; $display("FAIL pass_core_done: got %h expected f", core_done); end
            end
            if (c == 41) begin
                checks++; if (finish_req !== 1'b0) begin errors++; $display("FAIL pass_finish_early: got %b expected 0", finish_req); end
            end
            if (c == 42) begin
                checks++; if (finish_req !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL pass_finish: got %b%b expected 11", finish_req, done); end
            end
            if (c == 43) begin
                checks++; if (finish_req !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL pass_finish_pulse: got %b%b expected 01", finish_req, done); end
            end
        end
        checks++; if (num_cycles !== 32'd41) begin errors++; $display("FAIL pass_num_cycles: got %0d expected 41", num_cycles); end
        stat_sel = 2'd0; #1;
        checks++; if (stat_num_inst !== 32'd10) begin errors++; $display("FAIL pass_inst_core0: got %0d expected 10", stat_num_inst); end
        stat_sel = 2'd3; #1;
        checks++; if (stat_num_inst !== 32'd40) begin errors++; $display("FAIL pass_inst_core3: got %0d expected 40", stat_num_inst); end
    endtask

    task automatic test_simultaneous_fail();
        do_reset();
        stats_en    = 1'b1;
        max_cycles  = 32'd1000;
        inst_retire = '1;
        for (int c = 0; c <= 10; c++) begin
            status[0*SW +: SW] = (c >= 2) ? 32'd1 : 32'd0;
            status[1*SW +: SW] = (c >= 7) ? 32'd9 : (c >= 5) ? 32'd7 : 32'd0;
            status[2*SW +: SW] = (c >= 5) ? 32'd5 : 32'd0;
            tick();
            if (c == 4) begin
                checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL fail_early_verdict: got %0d expected 0", verdict); end
            end
            if (c == 5) begin
                checks++; if (verdict !== 2'd2) begin errors++; $display("FAIL fail_verdict: got %0d expected 2", verdict); end
                checks++; if (core_done !== 4'b0111) begin errors++; $display("FAIL fail_core_done: got %b expected 0111", core_done); end
            end
        end
        checks++; if (fail_core !== 2'd1) begin errors++; $display("FAIL fail_core: got %0d expected 1", fail_core); end
        checks++; if (fail_status !== 32'd7) begin errors++; $display("FAIL fail_status: got %0d expected 7", fail_status); end
        checks++; if (verdict !== 2'd2) begin errors++; $display("FAIL fail_verdict_hold: got %0d expected 2", verdict); end
        checks++; if (num_cycles !== 32'd6) begin errors++; $display("FAIL fail_num_cycles_frozen: got %0d expected 6", num_cycles); end
        stat_sel = 2'd0; #1;
        checks++; if (stat_num_inst !== 32'd3) begin errors++; $display("FAIL fail_inst_core0: got %0d expected 3", stat_num_inst); end
        stat_sel = 2'd1; #1;
        checks++; if (stat_num_inst !== 32'd6) begin errors++; $display("FAIL fail_inst_core1: got %0d expected 6", stat_num_inst); end
        stat_sel = 2'd3; #1;
        checks++; if (stat_num_inst !== 32'd6) begin errors++; $display("FAIL fail_inst_core3_frozen: got %0d expected 6", stat_num_inst); end
    endtask

    task automatic test_timeout();
        logic seen_finish;
        do_reset();
        stats_en   = 1'b1;
        max_cycles = 32'd50;
        for (int c = 0; c <= 52; c++) begin
            tick();
            if (c == 49) begin
                checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", verdict); end
            end
            if (c == 50) begin
                checks++; if (verdict !== 2'd3) begin errors++; $display("FAIL timeout_verdict: got %0d expected 3", verdict); end
                checks++; if (num_cycles !== 32'd51) begin errors++; $display("FAIL timeout_num_cycles: got %0d expected 51", num_cycles); end
            end
            if (c == 52) begin
                checks++; if (finish_req !== 1'b1) begin errors++; $display("FAIL timeout_finish: got %b expected 1", finish_req); end
            end
        end
        do_reset();
        stats_en    = 1'b1;
        max_cycles  = '0;
        seen_finish = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (finish_req === 1'b1) seen_finish = 1'b1;
        end
        checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL notimeout_verdict: got %0d expected 0", verdict); end
        checks++; if (seen_finish !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL notimeout_finish: got %b%b expected 00", seen_finish, done); end
        checks++; if (num_cycles !== 32'd10000) begin errors++; $display("FAIL notimeout_num_cycles: got %0d expected 10000", num_cycles); end
    endtask

    task automatic test_priority();
        logic [31:0] last_val;
        logic [1:0]  exp_verdict;
        for (int run = 0; run < 2; run++) begin
            last_val    = (run == 0) ? 32'd1 : 32'd3;
            exp_verdict = (run == 0) ? 2'd1 : 2'd2;
            do_reset();
            stats_en   = 1'b1;
            max_cycles = 32'd20;
            for (int c = 0; c <= 20; c++) begin
                for (int i = 0; i < 3; i++) status[i*SW +: SW] = (c >= 1) ? 32'd1 : 32'd0;
                status[3*SW +: SW] = (c >= 20) ? last_val : 32'd0;
                tick();
                if (c == 19) begin
                    checks++; if (verdict !== 2'd0) begin errors++; $display("FAIL prio_early run%0d: got %0d expected 0", run, verdict); end
                end
            end
            checks++; if (verdict !== exp_verdict) begin errors++; $display("FAIL prio_verdict run%0d: got %0d expected %0d", run, verdict, exp_verdict); end
            if (run == 1) begin
                checks++; if (fail_core !== 2'd3 || fail_status !== 32'd3) begin errors++; $display("FAIL prio_fail_info: got core %0d status %0d expected core 3 status 3", fail_core, fail_status); end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        stats_en   = 1'b1;
        max_cycles = 32'd1000;
        for (int c = 0; c <= 3; c++) begin
            status = (c >= 3) ? {NC{32'd1}} : '0;
            tick();
        end
        checks++; if (verdict !== 2'd1) begin errors++; $display("FAIL drain_verdict: got %0d expected 1", verdict); end
        tick();
        checks++; if (finish_req !== 1'b0) begin errors++; $display("FAIL drain_no_finish_pre: got %b expected 0", finish_req); end
        reset_n = 1'b0;
        status  = '0;
        tick();
        checks++; if (finish_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL drain_abort_finish: got %b%b expected 00", finish_req, done); end
        checks++; if (verdict !== 2'd0 || core_done !== 4'h0) begin errors++; $display("FAIL drain_abort_state: got verdict %0d done %h expected 0 0", verdict, core_done); end
        checks++; if (num_cycles !== 32'd0 || fail_status !== 32'd0 || fail_core !== 2'd0) begin errors++; $display("FAIL drain_abort_regs: got %0d %0d %0d expected 0 0 0", num_cycles, fail_status, fail_core); end
        reset_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            status = (c >= 2) ? {NC{32'd1}} : '0;
            tick();
            if (c == 2) begin
                checks++; if (verdict !== 2'd1) begin errors++; $display("FAIL rerun_verdict: got %0d expected 1", verdict); end
            end
        end
        checks++; if (finish_req !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL rerun_finish: got %b%b expected 11", finish_req, done); end
    endtask

    task automatic test_saturation();
        do_reset();
        stats_en = 1'b1;
        s_retire = '1;
        repeat (20) tick();
        checks++; if (s_num_cycles !== 4'd15) begin errors++; $display("FAIL sat_num_cycles: got %0d expected 15", s_num_cycles); end
        for (int k = 0; k < 3; k++) begin
            s_sel = 2'(k); #1;
            checks++; if (s_num_inst !== 4'd15) begin errors++; $display("FAIL sat_inst core%0d: got %0d expected 15", k, s_num_inst); end
        end
        s_sel = 2'd3; #1;
        checks++; if (s_num_inst !== 4'd0) begin errors++; $display("FAIL sat_sel_out_of_range: got %0d expected 0", s_num_inst); end
        checks++; if (s_verdict !== 2'd0) begin errors++; $display("FAIL sat_verdict: got %0d expected 0", s_verdict); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_all_pass();
        test_simultaneous_fail();
        test_timeout();
        test_priority();
        test_reset_mid_drain();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
